// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent receiver and transmitter on one clock.
// Each direction is a registered FSM with a comb next-state/next-output process.
module uart_transceiver #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_rx_serial,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    input  logic       i_tx_dv,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_active,
    output logic       o_tx_serial,
    output logic       o_tx_done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_STOP    = 3'd3;
    localparam logic [2:0] S_CLEANUP = 3'd4;

    logic             r_rx_meta;
    logic             r_rx_sync;
    logic [2:0]       r_rx_state, rx_state_n;
    logic [CNT_W-1:0] r_rx_cnt, rx_cnt_n;
    logic [2:0]       r_rx_idx, rx_idx_n;
    logic [7:0]       r_rx_shift, rx_shift_n;
    logic [7:0]       rx_byte_n;
    logic             rx_dv_n;

    logic [2:0]       r_tx_state, tx_state_n;
    logic [CNT_W-1:0] r_tx_cnt, tx_cnt_n;
    logic [2:0]       r_tx_idx, tx_idx_n;
    logic [2:0]       tx_idx_inc;
    logic [7:0]       r_tx_data, tx_data_n;
    logic             tx_serial_n, tx_active_n, tx_done_n;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx_serial;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            o_rx_byte  <= '0;
            o_rx_dv    <= 1'b0;
        end else begin
            r_rx_state <= rx_state_n;
            r_rx_cnt   <= rx_cnt_n;
            r_rx_idx   <= rx_idx_n;
            r_rx_shift <= rx_shift_n;
            o_rx_byte  <= rx_byte_n;
            o_rx_dv    <= rx_dv_n;
        end
    end

    // RX: confirm start at mid-bit, then sample each following bit one bit period later
    always_comb begin
        rx_state_n = r_rx_state;
        rx_cnt_n   = r_rx_cnt;
        rx_idx_n   = r_rx_idx;
        rx_shift_n = r_rx_shift;
        rx_byte_n  = o_rx_byte;
        rx_dv_n    = 1'b0;
        case (r_rx_state)
            S_IDLE: begin
                rx_cnt_n = '0;
                rx_idx_n = '0;
                if (!r_rx_sync) rx_state_n = S_START;
            end
            S_START: begin
                if (r_rx_cnt == HALF_BIT) begin
                    rx_cnt_n   = '0;
                    rx_state_n = r_rx_sync ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_n = r_rx_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (r_rx_cnt < BIT_LAST) begin
                    rx_cnt_n = r_rx_cnt + CNT_W'(1);
                end else begin
                    rx_cnt_n             = '0;
                    rx_shift_n[r_rx_idx] = r_rx_sync;
                    if (r_rx_idx == 3'd7) begin
                        rx_idx_n   = '0;
                        rx_state_n = S_STOP;
                    end else begin
                        rx_idx_n = r_rx_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (r_rx_cnt < BIT_LAST) begin
                    rx_cnt_n = r_rx_cnt + CNT_W'(1);
                end else begin
                    rx_cnt_n   = '0;
                    rx_state_n = S_CLEANUP;
                    if (r_rx_sync) begin
                        rx_byte_n = r_rx_shift;
                        rx_dv_n   = 1'b1;
                    end
                end
            end
            S_CLEANUP: rx_state_n = S_IDLE;
            default:   rx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_tx_state  <= S_IDLE;
            r_tx_cnt    <= '0;
            r_tx_idx    <= '0;
            r_tx_data   <= '0;
            o_tx_serial <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
        end else begin
            r_tx_state  <= tx_state_n;
            r_tx_cnt    <= tx_cnt_n;
            r_tx_idx    <= tx_idx_n;
            r_tx_data   <= tx_data_n;
            o_tx_serial <= tx_serial_n;
            o_tx_active <= tx_active_n;
            o_tx_done   <= tx_done_n;
        end
    end

    assign tx_idx_inc = r_tx_idx + 3'd1;

    // TX: the registered line level changes on the edge that ends each bit period
    always_comb begin
        tx_state_n  = r_tx_state;
        tx_cnt_n    = r_tx_cnt;
        tx_idx_n    = r_tx_idx;
        tx_data_n   = r_tx_data;
        tx_serial_n = o_tx_serial;
        tx_active_n = o_tx_active;
        tx_done_n   = 1'b0;
        case (r_tx_state)
            S_IDLE: begin
                tx_serial_n = 1'b1;
                tx_cnt_n    = '0;
                tx_idx_n    = '0;
                if (i_tx_dv) begin
                    tx_data_n   = i_tx_byte;
                    tx_serial_n = 1'b0;
                    tx_active_n = 1'b1;
                    tx_state_n  = S_START;
                end
            end
            S_START: begin
                if (r_tx_cnt < BIT_LAST) begin
                    tx_cnt_n = r_tx_cnt + CNT_W'(1);
                end else begin
                    tx_cnt_n    = '0;
                    tx_serial_n = r_tx_data[0];
                    tx_state_n  = S_DATA;
                end
            end
            S_DATA: begin
                if (r_tx_cnt < BIT_LAST) begin
                    tx_cnt_n = r_tx_cnt + CNT_W'(1);
                end else begin
                    tx_cnt_n = '0;
                    if (r_tx_idx == 3'd7) begin
                        tx_idx_n    = '0;
                        tx_serial_n = 1'b1;
                        tx_state_n  = S_STOP;
                    end else begin
                        tx_idx_n    = tx_idx_inc;
                        tx_serial_n = r_tx_data[tx_idx_inc];
                    end
                end
            end
            S_STOP: begin
                if (r_tx_cnt < BIT_LAST) begin
                    tx_cnt_n = r_tx_cnt + CNT_W'(1);
                end else begin
                    tx_cnt_n    = '0;
                    tx_done_n   = 1'b1;
                    tx_active_n = 1'b0;
                    tx_state_n  = S_CLEANUP;
                end
            end
            S_CLEANUP: begin
                tx_serial_n = 1'b1;
                tx_state_n  = S_IDLE;
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: frame-level reference model,
// randomized bytes, TX/RX/glitch/framing/busy/loopback/reset scenarios.
module tb_uart_transceiver;

    localparam int CPB = 87;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_drive;
    logic       loopback;
    logic       rx_serial;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       tx_active;
    logic       tx_serial;
    logic       tx_done;

    int         n_cmp = 0;
    int         n_err = 0;
    int         dv_count = 0;
    int         done_count = 0;
    logic [7:0] dv_last = 8'h00;
    logic [7:0] exp_rx = 8'h00;

    always #5 clk = ~clk;

    assign rx_serial = loopback ? tx_serial : rx_drive;

    uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_rx_serial (rx_serial),
        .o_rx_dv     (rx_dv),
        .o_rx_byte   (rx_byte),
        .i_tx_dv     (tx_dv),
        .i_tx_byte   (tx_byte),
        .o_tx_active (tx_active),
        .o_tx_serial (tx_serial),
        .o_tx_done   (tx_done)
    );

    // Pulse monitors, sampled on the inactive edge
    always @(negedge clk) begin
        if (rx_dv) begin
            dv_count++;
            dv_last = rx_byte;
        end
        if (tx_done) done_count++;
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        exp_rx = 8'h00;
    endtask

    task automatic test_reset();
        apply_reset();
        if (tx_serial !== 1'b1) begin n_err++; $display("FAIL reset_tx_serial: got %b want 1", tx_serial); end
        n_cmp++;
        if (tx_active !== 1'b0) begin n_err++; $display("FAIL reset_tx_active: got %b want 0", tx_active); end
        n_cmp++;
        if (tx_done !== 1'b0) begin n_err++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
        n_cmp++;
        if (rx_dv !== 1'b0) begin n_err++; $display("FAIL reset_rx_dv: got %b want 0", rx_dv); end
        n_cmp++;
        if (rx_byte !== 8'h00) begin n_err++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte); end
        n_cmp++;
    endtask

    // Send one byte; when busy, poke i_tx_dv mid-frame and during cleanup and scramble i_tx_byte
    task automatic test_tx(input logic [7:0] b, input bit busy);
        logic [9:0] frame;
        int         t;
        int         d0;
        frame = {1'b1, b, 1'b0};
        d0    = done_count;
        @(posedge clk);
        #1;
        tx_dv   = 1'b1;
        tx_byte = b;
        cycles(1);
        tx_dv = 1'b0;
        t     = 0;
        if (tx_active !== 1'b1) begin n_err++; $display("FAIL tx_active_start: got %b want 1", tx_active); end
        n_cmp++;
        for (int k = 0; k < 10; k++) begin
            while (t < k * CPB + CPB / 2) begin
                tx_dv = busy && (t == 3 * CPB);
                if (busy) tx_byte = (t == 3 * CPB) ? 8'h12 : 8'($urandom);
                cycles(1);
                t++;
            end
            tx_dv = 1'b0;
            if (tx_serial !== frame[k]) begin
                n_err++;
                $display("FAIL tx_bit%0d byte %h: got %b want %b", k, b, tx_serial, frame[k]);
            end
            n_cmp++;
        end
        cycles(10 * CPB - t);
        if (tx_done !== 1'b1 || tx_active !== 1'b0 || tx_serial !== 1'b1) begin
            n_err++;
            $display("FAIL tx_end: done/active/serial got %b%b%b want 101", tx_done, tx_active, tx_serial);
        end
        n_cmp++;
        if (busy) begin
            tx_dv   = 1'b1;
            tx_byte = 8'h12;
        end
        cycles(1);
        tx_dv = 1'b0;
        if (tx_done !== 1'b0) begin n_err++; $display("FAIL tx_done_width: got %b want 0", tx_done); end
        n_cmp++;
        cycles(3);
        if (tx_active !== 1'b0 || tx_serial !== 1'b1) begin
            n_err++;
            $display("FAIL tx_idle_after: active/serial got %b%b want 01", tx_active, tx_serial);
        end
        n_cmp++;
        if (done_count - d0 !== 1) begin
            n_err++;
            $display("FAIL tx_done_count: got %0d want 1", done_count - d0);
        end
        n_cmp++;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx_drive = v;
        cycles(n);
    endtask

    task automatic test_rx(input logic [7:0] b, input int start_len, input logic stop_bit);
        int d0;
        d0 = dv_count;
        if (stop_bit) exp_rx = b;
        drive_bit(1'b0, start_len);
        for (int k = 0; k < 8; k++) drive_bit(b[k], CPB);
        drive_bit(stop_bit, CPB);
        if (rx_byte !== exp_rx) begin
            n_err++;
            $display("FAIL rx_byte_by_stop_end: got %h want %h", rx_byte, exp_rx);
        end
        n_cmp++;
        drive_bit(1'b1, 2 * CPB);
        if (dv_count - d0 !== (stop_bit ? 1 : 0)) begin
            n_err++;
            $display("FAIL rx_dv_count byte %h: got %0d want %0d", b, dv_count - d0, stop_bit ? 1 : 0);
        end
        n_cmp++;
        if (stop_bit && dv_last !== b) begin
            n_err++;
            $display("FAIL rx_dv_byte: got %h want %h", dv_last, b);
        end
        if (stop_bit) n_cmp++;
        if (rx_byte !== exp_rx) begin
            n_err++;
            $display("FAIL rx_byte_hold: got %h want %h", rx_byte, exp_rx);
        end
        n_cmp++;
    endtask

    task automatic test_glitch();
        int d0;
        d0 = dv_count;
        drive_bit(1'b0, 20);
        drive_bit(1'b1, 2 * CPB);
        if (dv_count - d0 !== 0) begin
            n_err++;
            $display("FAIL rx_glitch_dv: got %0d want 0", dv_count - d0);
        end
        n_cmp++;
        if (rx_byte !== exp_rx) begin
            n_err++;
            $display("FAIL rx_glitch_byte: got %h want %h", rx_byte, exp_rx);
        end
        n_cmp++;
        test_rx(8'($urandom), CPB, 1'b1);
    endtask

    task automatic test_loopback(input logic [7:0] b);
        int dv0;
        int dn0;
        dv0 = dv_count;
        dn0 = done_count;
        loopback = 1'b1;
        @(posedge clk);
        #1;
        tx_dv   = 1'b1;
        tx_byte = b;
        cycles(1);
        tx_dv = 1'b0;
        cycles(11 * CPB);
        exp_rx = b;
        if (dv_count - dv0 !== 1 || done_count - dn0 !== 1) begin
            n_err++;
            $display("FAIL loop_pulses byte %h: dv %0d done %0d want 1 1", b, dv_count - dv0, done_count - dn0);
        end
        n_cmp++;
        if (rx_byte !== b) begin
            n_err++;
            $display("FAIL loop_byte: got %h want %h", rx_byte, b);
        end
        n_cmp++;
        loopback = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int dv0;
        int dn0;
        loopback = 1'b1;
        @(posedge clk);
        #1;
        tx_dv   = 1'b1;
        tx_byte = 8'($urandom);
        cycles(1);
        tx_dv = 1'b0;
        cycles(4 * CPB + 13);
        dv0 = dv_count;
        dn0 = done_count;
        apply_reset();
        if (tx_serial !== 1'b1 || tx_active !== 1'b0 || rx_byte !== 8'h00) begin
            n_err++;
            $display("FAIL midreset_state: serial %b active %b rx_byte %h want 1 0 00", tx_serial, tx_active, rx_byte);
        end
        n_cmp++;
        cycles(12 * CPB);
        if (dv_count - dv0 !== 0 || done_count - dn0 !== 0) begin
            n_err++;
            $display("FAIL midreset_pulses: dv %0d done %0d want 0 0", dv_count - dv0, done_count - dn0);
        end
        n_cmp++;
        if (tx_serial !== 1'b1 || tx_active !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_idle: serial %b active %b want 1 0", tx_serial, tx_active);
        end
        n_cmp++;
        loopback = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rx_drive = 1'b1;
        loopback = 1'b0;
        tx_dv    = 1'b0;
        tx_byte  = 8'h00;
        test_reset();
        test_tx(8'hAB, 1'b0);
        test_tx(8'hAB, 1'b1);
        for (int i = 0; i < 3; i++) test_tx(8'($urandom), 1'b0);
        test_rx(8'h3F, 97, 1'b1);
        test_rx(8'h55, CPB, 1'b0);
        test_glitch();
        for (int i = 0; i < 4; i++) test_rx(8'($urandom), int'($urandom_range(97, 87)), 1'b1);
        test_loopback(8'h00);
        test_loopback(8'hFF);
        test_loopback(8'hA5);
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
